// File: rtl/sb_ram_model_pkg.sv
// Shared geometry definitions for the single-port-pair RAM model.
// The four modes differ only in word width, so every per-mode constant
// is derived from the mode code.
`ifndef SB_RAM_MODEL_PKG_SV
`define SB_RAM_MODEL_PKG_SV

package sb_ram_model_pkg;

    localparam int unsigned MEM_BITS = 4096;

    localparam logic [1:0] MODE_256X16 = 2'd0;
    localparam logic [1:0] MODE_512X8  = 2'd1;
    localparam logic [1:0] MODE_1024X4 = 2'd2;
    localparam logic [1:0] MODE_2048X2 = 2'd3;

    // Word width in bits for a mode.
    function automatic int unsigned mode_width(input logic [1:0] mode);
        case (mode)
            MODE_256X16: return 16;
            MODE_512X8:  return 8;
            MODE_1024X4: return 4;
            MODE_2048X2: return 2;
            default:     return 16;
        endcase
    endfunction

    // Number of significant address bits for a mode.
    function automatic int unsigned mode_addr_width(input logic [1:0] mode);
        case (mode)
            MODE_256X16: return 8;
            MODE_512X8:  return 9;
            MODE_1024X4: return 10;
            MODE_2048X2: return 11;
            default:     return 8;
        endcase
    endfunction

    // Word depth for a mode.
    function automatic int unsigned mode_depth(input logic [1:0] mode);
        return MEM_BITS / mode_width(mode);
    endfunction

    // Lane mask covering the live bits of a word in a mode.
    function automatic logic [15:0] mode_lane_mask(input logic [1:0] mode);
        case (mode)
            MODE_256X16: return 16'hFFFF;
            MODE_512X8:  return 16'h00FF;
            MODE_1024X4: return 16'h000F;
            MODE_2048X2: return 16'h0003;
            default:     return 16'hFFFF;
        endcase
    endfunction

endpackage

`endif

// File: rtl/sb_ram_mode_map.sv
// Maps a word address to its bit offset in the flat storage array and the
// mask of live bits in that word. Upper address bits beyond the mode's
// address width are dropped here, so callers never see them.
module sb_ram_mode_map
    import sb_ram_model_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [10:0] addr,
    output logic [11:0] offset,
    output logic [15:0] lane_mask
);

    // Offset is the truncated address scaled by the word width.
    always_comb begin
        offset    = 12'd0;
        lane_mask = mode_lane_mask(mode);
        case (mode)
            MODE_256X16: offset = {addr[7:0], 4'b0000};
            MODE_512X8:  offset = {addr[8:0], 3'b000};
            MODE_1024X4: offset = {addr[9:0], 2'b00};
            MODE_2048X2: offset = {addr[10:0], 1'b0};
            default:     offset = 12'd0;
        endcase
    end

endmodule

// File: rtl/sb_ram_model.sv
// Behavioural model of a 4 Kbit block RAM with independently configurable
// read and write geometries over one flat bit array. Reads are registered
// and read-first; reset clears only the read register, never the storage.
module sb_ram_model
    import sb_ram_model_pkg::*;
#(
    parameter int                     READ_MODE  = 0,
    parameter int                     WRITE_MODE = 0,
    parameter logic [MEM_BITS-1:0]    INIT_VALUE = '0
) (
    input  logic        C,
    input  logic        R,
    input  logic        WE,
    input  logic        WCLKE,
    input  logic [10:0] WADDR,
    input  logic [15:0] WDATA,
    input  logic [15:0] MASK,
    input  logic        RE,
    input  logic        RCLKE,
    input  logic [10:0] RADDR,
    output logic [15:0] RDATA
);

    localparam logic [1:0] RMODE = READ_MODE[1:0];
    localparam logic [1:0] WMODE = WRITE_MODE[1:0];

    logic [MEM_BITS-1:0] mem_r   = INIT_VALUE;
    logic [15:0]         rdata_r = 16'h0000;

    logic [11:0] woff_s;
    logic [15:0] wlane_s;
    logic [11:0] roff_s;
    logic [15:0] rlane_s;
    logic        we_s;
    logic        re_s;
    logic [15:0] wbits_s;
    logic [15:0] rword_s;

    sb_ram_mode_map u_wmap (
        .mode      (WMODE),
        .addr      (WADDR),
        .offset    (woff_s),
        .lane_mask (wlane_s)
    );

    sb_ram_mode_map u_rmap (
        .mode      (RMODE),
        .addr      (RADDR),
        .offset    (roff_s),
        .lane_mask (rlane_s)
    );

    // Qualify requests (unknown controls count as inactive) and select the
    // bits to write and the word to read.
    always_comb begin
        we_s = (WE === 1'b1) && (WCLKE === 1'b1);
        re_s = (RE === 1'b1) && (RCLKE === 1'b1);
        if (WMODE == MODE_256X16) begin
            wbits_s = wlane_s & ~MASK;
        end else begin
            wbits_s = wlane_s;
        end
        rword_s = 16'(mem_r >> roff_s) & rlane_s;
    end

    // Storage update: bit-granular so the write mask and narrow modes share
    // one path. Offsets wrap in 12 bits only for lanes that are masked off.
    always_ff @(posedge C) begin
        if (!R && we_s) begin
            for (int i = 0; i < 16; i++) begin
                if (wbits_s[i]) begin
                    mem_r[woff_s + 12'(i)] <= WDATA[i];
                end
            end
        end
    end

    // Read register: samples pre-write storage, so a same-cycle collision
    // returns the old word.
    always_ff @(posedge C) begin
        if (R) begin
            rdata_r <= 16'h0000;
        end else if (re_s) begin
            rdata_r <= rword_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign RDATA = rdata_r;

endmodule

// File: tb/tb_sb_ram_model.sv
// Directed bench for sb_ram_model: three instances cover mode 0/0,
// mixed write-2-bit/read-16-bit with a nonzero initial image, and
// write-16-bit/read-4-bit.
module tb_sb_ram_model;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we    [3];
    logic        wclke [3];
    logic [10:0] waddr [3];
    logic [15:0] wdata [3];
    logic [15:0] mask  [3];
    logic        re    [3];
    logic        rclke [3];
    logic [10:0] raddr [3];
    logic [15:0] rdata [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sb_ram_model #(.READ_MODE(0), .WRITE_MODE(0)) u_dut0 (
        .C(clk), .R(rst), .WE(we[0]), .WCLKE(wclke[0]), .WADDR(waddr[0]),
        .WDATA(wdata[0]), .MASK(mask[0]), .RE(re[0]), .RCLKE(rclke[0]),
        .RADDR(raddr[0]), .RDATA(rdata[0])
    );

    sb_ram_model #(.READ_MODE(0), .WRITE_MODE(3), .INIT_VALUE(4096'hDEAD_BEEF)) u_dut1 (
        .C(clk), .R(rst), .WE(we[1]), .WCLKE(wclke[1]), .WADDR(waddr[1]),
        .WDATA(wdata[1]), .MASK(mask[1]), .RE(re[1]), .RCLKE(rclke[1]),
        .RADDR(raddr[1]), .RDATA(rdata[1])
    );

    sb_ram_model #(.READ_MODE(2), .WRITE_MODE(0)) u_dut2 (
        .C(clk), .R(rst), .WE(we[2]), .WCLKE(wclke[2]), .WADDR(waddr[2]),
        .WDATA(wdata[2]), .MASK(mask[2]), .RE(re[2]), .RCLKE(rclke[2]),
        .RADDR(raddr[2]), .RDATA(rdata[2])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge, then drop all requests.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; wclke[k] = 1'b0; re[k] = 1'b0; rclke[k] = 1'b0;
            mask[k] = 16'h0000;
        end
        rst = 1'b0;
    endtask

    task automatic set_wr(input int d, input logic [10:0] a, input logic [15:0] v, input logic [15:0] m);
        we[d] = 1'b1; wclke[d] = 1'b1; waddr[d] = a; wdata[d] = v; mask[d] = m;
    endtask

    task automatic set_rd(input int d, input logic [10:0] a);
        re[d] = 1'b1; rclke[d] = 1'b1; raddr[d] = a;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; wclke[k] = 1'b0; waddr[k] = 11'd0; wdata[k] = 16'h0000;
            mask[k] = 16'h0000; re[k] = 1'b0; rclke[k] = 1'b0; raddr[k] = 11'd0;
        end
        #1;
        chk("t0_rdata0", rdata[0], 16'h0000);
        chk("t0_rdata1", rdata[1], 16'h0000);
        chk("t0_rdata2", rdata[2], 16'h0000);

        // Mode 0/0 basic write/read; write address carries ignored upper bits.
        set_wr(0, 11'h710, 16'hA5C3, 16'h0000); step();
        chk("hold_no_read", rdata[0], 16'h0000);
        set_rd(0, 11'h010); step();
        chk("basic_read", rdata[0], 16'hA5C3);
        step();
        chk("idle_hold", rdata[0], 16'hA5C3);

        // Write mask.
        set_wr(0, 11'h020, 16'hFFFF, 16'h0000); step();
        set_wr(0, 11'h020, 16'h0000, 16'hFF00); step();
        set_rd(0, 11'h020); step();
        chk("mask_write", rdata[0], 16'hFF00);

        // Read-first collision.
        set_wr(0, 11'h005, 16'h1111, 16'h0000); step();
        set_wr(0, 11'h005, 16'h2222, 16'h0000); set_rd(0, 11'h005); step();
        chk("collide_old", rdata[0], 16'h1111);
        set_rd(0, 11'h005); step();
        chk("collide_new", rdata[0], 16'h2222);

        // Reset suppresses write and clears RDATA.
        set_wr(0, 11'h003, 16'h7777, 16'h0000); step();
        set_wr(0, 11'h006, 16'hBEEF, 16'h0000); step();
        set_rd(0, 11'h006); step();
        chk("pre_reset", rdata[0], 16'hBEEF);
        rst = 1'b1; set_wr(0, 11'h003, 16'h0001, 16'h0000); set_rd(0, 11'h006); step();
        chk("reset_rdata", rdata[0], 16'h0000);
        set_rd(0, 11'h003); step();
        chk("reset_keeps_mem", rdata[0], 16'h7777);

        // Clock-enable gating on both ports.
        we[0] = 1'b1; wclke[0] = 1'b0; waddr[0] = 11'h003; wdata[0] = 16'hAAAA;
        re[0] = 1'b1; rclke[0] = 1'b0; raddr[0] = 11'h006; step();
        chk("rclke_gate", rdata[0], 16'h7777);
        set_rd(0, 11'h003); step();
        chk("wclke_gate", rdata[0], 16'h7777);

        // Initial image and mixed geometry: 2-bit writes, 16-bit read.
        set_rd(1, 11'h001); step();
        chk("init_word1", rdata[1], 16'hDEAD);
        set_wr(1, 11'h000, 16'h0001, 16'hFFFF); step();
        set_wr(1, 11'h001, 16'h0002, 16'hFFFF); step();
        set_wr(1, 11'h002, 16'h0003, 16'hFFFF); step();
        set_wr(1, 11'h003, 16'h0000, 16'hFFFF); step();
        set_rd(1, 11'h000); step();
        chk("mixed_w3_r0", rdata[1], 16'hBE39);

        // 16-bit write, 4-bit reads of its nibbles.
        set_wr(2, 11'h002, 16'h1234, 16'h0000); step();
        set_rd(2, 11'h008); step();
        chk("nib_addr8", rdata[2], 16'h0004);
        set_rd(2, 11'h009); step();
        chk("nib_addr9", rdata[2], 16'h0003);
        set_rd(2, 11'h40B); step();
        chk("nib_addr11_alias", rdata[2], 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
